fetch_unit: RTL and testbench

//  Parametrised instruction-fetch front end for the 5-stage RISC-V pipeline; replaces the bare PC reg/adder/mux + IF_ID latch.

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fetch_fifo.sv | 81 ++++++++
 rtl/fetch_unit.sv | 158 +++++++++++++++
 tb/tb_fetch_unit.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int FQ_PC_W  = 9;
  localparam int FQ_INS_W = 32;

  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_HALT   = 7'h7F;

  typedef logic [1:0] bht_ctr_t;
  localparam bht_ctr_t BHT_INIT = 2'b01;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [FQ_PC_W-1:0]  pc;
    logic [FQ_INS_W-1:0] instr;
    logic                pred_taken;
  } fq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; the head is read straight from storage (no
// push-to-head bypass) and reads as zero while the FIFO is empty.
module fetch_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  T                       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output T                       head_data,
  output logic                   head_valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  T                 mem_q [DEPTH];
  T                 mem_d [DEPTH];

  // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; only the pointers do, and the empty head is masked to zero below.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_valid = (count_q != '0);
  assign head_data  = head_valid ? mem_q[rd_ptr_q] : '0;
  assign count      = count_q;

  // The issue credit in the fetch unit must keep these from ever firing.
  always_ff @(posedge clk) begin
    if (!reset && !flush) begin
      assert (!(push && !pop && count_q == CNT_W'(DEPTH)));
      assert (!(pop && count_q == '0));
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC/issue control, BHT-based branch prediction,
// halt handling and EX redirect, feeding decode through a small fetch queue.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int PC_W    = FQ_PC_W,
  parameter int INS_W   = FQ_INS_W,
  parameter int DEPTH   = 4,
  parameter int BHT_IDX = 4
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [INS_W-1:0] imem_rdata,
  output logic             id_valid,
  input  logic             id_ready,
  output logic [INS_W-1:0] id_instr,
  output logic [PC_W-1:0]  id_pc,
  output logic             id_pred_taken,
  input  logic             ex_redirect,
  input  logic [PC_W-1:0]  ex_target,
  input  logic             ex_br_valid,
  input  logic [PC_W-1:0]  ex_br_pc,
  input  logic             ex_br_taken
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int BHT_N = 1 << BHT_IDX;

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            rsp_v_q, rsp_v_d;
  logic [PC_W-1:0] rsp_pc_q, rsp_pc_d;
  bht_ctr_t        bht_q [BHT_N];
  bht_ctr_t        bht_d [BHT_N];

  logic             fifo_push, fifo_pop, fifo_flush;
  fq_entry_t        push_entry, head_entry;
  logic [CNT_W-1:0] fifo_count;
  logic             issue_ok;

  // Immediate decode of the returning word; offsets wrap at the PC width.
  logic [6:0]         rsp_op;
  logic [31:0]        b_imm, j_imm;
  logic               is_branch, is_jal, is_halt, pred_taken;
  logic [PC_W-1:0]    pred_tgt;
  logic [BHT_IDX-1:0] look_idx, train_idx;
  bht_ctr_t           look_ctr, train_ctr;

  assign rsp_op    = imem_rdata[6:0];
  assign b_imm     = {{19{imem_rdata[31]}}, imem_rdata[31], imem_rdata[7],
                      imem_rdata[30:25], imem_rdata[11:8], 1'b0};
  assign j_imm     = {{11{imem_rdata[31]}}, imem_rdata[31], imem_rdata[19:12],
                      imem_rdata[20], imem_rdata[30:21], 1'b0};
  assign is_branch = (rsp_op == OP_BRANCH);
  assign is_jal    = (rsp_op == OP_JAL);
  assign is_halt   = (rsp_op == OP_HALT);

  // Lookup and training both read the pre-edge table, so a same-cycle
  // update to the looked-up index is not visible to the prediction.
  assign look_idx   = rsp_pc_q[BHT_IDX+1:2];
  assign look_ctr   = bht_q[look_idx];
  assign train_idx  = ex_br_pc[BHT_IDX+1:2];
  assign train_ctr  = bht_q[train_idx];
  assign pred_taken = is_jal || (is_branch && look_ctr[1]);
  assign pred_tgt   = rsp_pc_q + (is_jal ? j_imm[PC_W-1:0] : b_imm[PC_W-1:0]);

  logic unused_ok;
  assign unused_ok = ^{b_imm[31:PC_W], j_imm[31:PC_W],
                       ex_br_pc[PC_W-1:BHT_IDX+2], ex_br_pc[1:0]};

  // An in-flight response already owns a queue slot, so it counts against the credit.
  assign issue_ok = !reset && (state_q == RUN) &&
                    (int'(fifo_count) + int'(rsp_v_q) + 1 <= DEPTH);

  assign push_entry = '{pc: rsp_pc_q, instr: imem_rdata, pred_taken: pred_taken};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    rsp_v_d    = 1'b0;
    rsp_pc_d   = rsp_pc_q;
    bht_d      = bht_q;
    imem_req   = 1'b0;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;

    if (ex_br_valid) begin
      if (ex_br_taken) bht_d[train_idx] = (train_ctr == 2'b11) ? train_ctr : train_ctr + 2'd1;
      else             bht_d[train_idx] = (train_ctr == 2'b00) ? train_ctr : train_ctr - 2'd1;
    end

    if (ex_redirect) begin
      fifo_flush = 1'b1;
      pc_d       = ex_target;
      state_d    = RUN;
    end else begin
      imem_req = issue_ok;
      fifo_pop = id_valid && id_ready;
      if (issue_ok) begin
        pc_d     = pc_q + PC_W'(4);
        rsp_v_d  = 1'b1;
        rsp_pc_d = pc_q;
      end
      if (rsp_v_q) begin
        fifo_push = 1'b1;
        // Halt and taken predictions both discard the request issued this cycle.
        if (is_halt) begin
          state_d = HALT;
          rsp_v_d = 1'b0;
          pc_d    = pc_q;
        end else if (pred_taken) begin
          pc_d    = pred_tgt;
          rsp_v_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      pc_q     <= '0;
      rsp_v_q  <= 1'b0;
      rsp_pc_q <= '0;
      bht_q    <= '{default: BHT_INIT};
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rsp_v_q  <= rsp_v_d;
      rsp_pc_q <= rsp_pc_d;
      bht_q    <= bht_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (fq_entry_t)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (fifo_push),
    .push_data  (push_entry),
    .pop        (fifo_pop),
    .flush      (fifo_flush),
    .head_data  (head_entry),
    .head_valid (id_valid),
    .count      (fifo_count)
  );

  assign imem_addr     = pc_q;
  assign id_instr      = head_entry.instr;
  assign id_pc         = head_entry.pc;
  assign id_pred_taken = head_entry.pred_taken;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios push expected deliveries,
// a negedge monitor pops and compares every accepted decode transfer.
module tb_fetch_unit;

  localparam int PC_W = 9;
  localparam int INS_W = 32;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] BEQ  = 32'h0200_0063;  // beq x0,x0,+0x20
  localparam logic [31:0] JAL  = 32'hFD1F_F06F;  // jal x0,-0x30
  localparam logic [31:0] HLT  = 32'h0000_007F;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             imem_req;
  logic [PC_W-1:0]  imem_addr;
  logic [INS_W-1:0] imem_rdata = '0;
  logic             id_valid;
  logic             id_ready = 1'b0;
  logic [INS_W-1:0] id_instr;
  logic [PC_W-1:0]  id_pc;
  logic             id_pred_taken;
  logic             ex_redirect = 1'b0;
  logic [PC_W-1:0]  ex_target = '0;
  logic             ex_br_valid = 1'b0;
  logic [PC_W-1:0]  ex_br_pc = '0;
  logic             ex_br_taken = 1'b0;

  always #5 clk = ~clk;

  fetch_unit #(.PC_W(PC_W), .INS_W(INS_W), .DEPTH(4), .BHT_IDX(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_instr      (id_instr),
    .id_pc         (id_pc),
    .id_pred_taken (id_pred_taken),
    .ex_redirect   (ex_redirect),
    .ex_target     (ex_target),
    .ex_br_valid   (ex_br_valid),
    .ex_br_pc      (ex_br_pc),
    .ex_br_taken   (ex_br_taken)
  );

  typedef struct {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
    logic            pred;
  } exp_t;

  logic [31:0] mem [128];
  exp_t        exp_q [$];
  int          n_checks = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Synchronous imem: request seen in cycle N returns its word during cycle N+1.
  initial begin
    logic [31:0] pend;
    forever begin
      @(negedge clk);
      pend = imem_req ? mem[imem_addr[PC_W-1:2]] : 32'h0;
      @(posedge clk);
      #1 imem_rdata = pend;
    end
  end

  always @(negedge clk) begin
    if (!reset && id_valid && id_ready && !ex_redirect) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_bad++;
        $display("FAIL unexpected_delivery: got pc 0x%0h instr 0x%0h, expected nothing", id_pc, id_instr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("id_pc", 32'(id_pc), 32'(e.pc));
        check("id_instr", id_instr, e.instr);
        check("id_pred_taken", 32'(id_pred_taken), 32'(e.pred));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [PC_W-1:0] pc, input logic pred);
    exp_t e;
    e.pc = pc;
    e.instr = mem[pc[PC_W-1:2]];
    e.pred = pred;
    exp_q.push_back(e);
  endtask

  task automatic push_seq(input logic [PC_W-1:0] start, input int n);
    for (int i = 0; i < n; i++) push_exp(start + PC_W'(4 * i), 1'b0);
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    id_ready = 1'b1;
    while (exp_q.size() != 0 && cyc < 200) begin
      tick();
      cyc++;
    end
    check("drain_remaining", 32'(exp_q.size()), 32'd0);
    id_ready = 1'b0;
  endtask

  task automatic redirect(input logic [PC_W-1:0] tgt);
    ex_redirect = 1'b1;
    ex_target = tgt;
    tick();
    ex_redirect = 1'b0;
  endtask

  task automatic train(input logic taken);
    ex_br_valid = 1'b1;
    ex_br_pc = 9'h010;
    ex_br_taken = taken;
    tick();
    ex_br_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_imem_req"}, 32'(imem_req), 32'd0);
    check({tag, "_id_valid"}, 32'(id_valid), 32'd0);
    check({tag, "_id_instr"}, id_instr, 32'd0);
    check({tag, "_id_pc"}, 32'(id_pc), 32'd0);
    check({tag, "_id_pred"}, 32'(id_pred_taken), 32'd0);
  endtask

  task automatic check_startup();
    @(negedge clk);
    check("c0_id_valid", 32'(id_valid), 32'd0);
    check("c0_imem_req", 32'(imem_req), 32'd1);
    check("c0_imem_addr", 32'(imem_addr), 32'd0);
    @(negedge clk);
    check("c1_id_valid", 32'(id_valid), 32'd0);
    @(negedge clk);
    check("c2_id_valid", 32'(id_valid), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = NOP;
    repeat (2) tick();
    @(negedge clk);
    check_reset_outputs("reset");

    // Sequential stream
    tick();
    reset = 1'b0;
    id_ready = 1'b1;
    push_seq(9'h000, 8);
    check_startup();
    tick();
    drain();

    // Backpressure: queue fills to DEPTH and fetch stops
    repeat (10) tick();
    @(negedge clk);
    check("bp_imem_req", 32'(imem_req), 32'd0);
    check("bp_id_valid", 32'(id_valid), 32'd1);
    check("bp_head_pc", 32'(id_pc), 32'h20);
    tick();
    push_seq(9'h020, 8);
    drain();

    // Branch prediction: saturate then weaken -> not taken; retrain -> taken
    mem[9'h010 >> 2] = BEQ;
    mem[9'h030 >> 2] = JAL;
    repeat (4) tick();
    train(1'b1); train(1'b1); train(1'b1); train(1'b0); train(1'b0);
    redirect(9'h010);
    push_exp(9'h010, 1'b0);
    push_seq(9'h014, 2);
    drain();
    repeat (8) tick();
    train(1'b1); train(1'b1);
    redirect(9'h010);
    push_exp(9'h010, 1'b1);
    push_exp(9'h030, 1'b1);
    push_seq(9'h000, 3);
    drain();
    repeat (8) tick();

    // Redirect with 3 queued + 1 in flight
    redirect(9'h040);
    @(negedge clk);
    check("rd1_imem_req", 32'(imem_req), 32'd1);
    check("rd1_imem_addr", 32'(imem_addr), 32'h40);
    repeat (4) tick();
    ex_redirect = 1'b1;
    ex_target = 9'h080;
    @(negedge clk);
    check("rd2_head_valid", 32'(id_valid), 32'd1);
    check("rd2_head_pc", 32'(id_pc), 32'h40);
    check("rd2_imem_req", 32'(imem_req), 32'd0);
    tick();
    ex_redirect = 1'b0;
    @(negedge clk);
    check("rd2_flushed", 32'(id_valid), 32'd0);
    check("rd2_fetch_addr", 32'(imem_addr), 32'h80);
    check("rd2_fetch_req", 32'(imem_req), 32'd1);
    push_seq(9'h080, 4);
    tick();
    drain();
    repeat (8) tick();

    // Halt, with the redirect cycle also presenting a ready that must be ignored
    mem[9'h00C >> 2] = HLT;
    id_ready = 1'b1;
    ex_redirect = 1'b1;
    ex_target = 9'h000;
    push_seq(9'h000, 4);
    tick();
    ex_redirect = 1'b0;
    drain();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("halt_no_req", 32'(imem_req), 32'd0);
      check("halt_empty", 32'(id_valid), 32'd0);
    end
    tick();
    redirect(9'h040);
    @(negedge clk);
    check("resume_req", 32'(imem_req), 32'd1);
    check("resume_addr", 32'(imem_addr), 32'h40);
    push_seq(9'h040, 4);
    tick();
    drain();
    repeat (8) tick();

    // Reset mid-run with full queue and trained BHT
    mem[9'h00C >> 2] = NOP;
    reset = 1'b1;
    tick();
    @(negedge clk);
    check_reset_outputs("midrst");
    check("midrst_imem_addr", 32'(imem_addr), 32'd0);
    tick();
    reset = 1'b0;
    id_ready = 1'b1;
    push_seq(9'h000, 4);
    push_exp(9'h010, 1'b0);
    push_seq(9'h014, 2);
    check_startup();
    tick();
    drain();

    repeat (4) tick();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
